// File: rtl/enc_onehot_to_bin_pipe.sv
// rtl/enc_onehot_to_bin_pipe.sv - registered one-hot to binary encoder with skid queue and error counter

// Two-entry queue: main drives the output, skid absorbs one beat of backpressure.
// Ports: in_t* accept side, out_t* drain side; in_tready is a register (~skid_valid).
module enc_onehot_skid_q #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_tvalid,
    output logic         in_tready,
    input  logic [W-1:0] in_tdata,
    output logic         out_tvalid,
    input  logic         out_tready,
    output logic [W-1:0] out_tdata
);

    logic         main_valid;
    logic [W-1:0] main_data;
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         consume;

    assign accept     = in_tvalid & in_tready;
    assign consume    = main_valid & out_tready;
    assign in_tready  = ~skid_valid;
    assign out_tvalid = main_valid;
    assign out_tdata  = main_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (consume && skid_valid) begin
            // Skid advances; a beat accepted now refills the skid slot.
            main_data  <= skid_data;
            skid_valid <= accept;
            if (accept) begin
                skid_data <= in_tdata;
            end
        end else if (!main_valid || consume) begin
            // Main is empty or draining with no skid beat behind it.
            main_valid <= accept;
            if (accept) begin
                main_data <= in_tdata;
            end
        end else if (accept) begin
            // Main is held by backpressure; park the new beat.
            skid_valid <= 1'b1;
            skid_data  <= in_tdata;
        end
    end

endmodule

// Ports: clk_i/rst_i clock and sync active-high reset; in_vld_i/in_rdy_o/data_i input beat;
// out_vld_o/out_rdy_i/data_o/err_o output beat; clr_cnt_i/err_cnt_o saturating error count.
module enc_onehot_to_bin_pipe #(
    parameter int OHOT_WTH    = 8,
    parameter int BIN_WTH     = 3,
    parameter int ERR_CNT_WTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_vld_i,
    output logic                   in_rdy_o,
    input  logic [OHOT_WTH-1:0]    data_i,
    output logic                   out_vld_o,
    input  logic                   out_rdy_i,
    output logic [BIN_WTH-1:0]     data_o,
    output logic                   err_o,
    input  logic                   clr_cnt_i,
    output logic [ERR_CNT_WTH-1:0] err_cnt_o
);

    logic [BIN_WTH-1:0]     enc_idx;
    logic                   enc_err;
    logic                   accept;
    logic [ERR_CNT_WTH-1:0] err_cnt_q;

    // Scan from the top down so the lowest set bit wins for multi-hot inputs.
    always_comb begin
        enc_idx = '0;
        for (int i = OHOT_WTH - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                enc_idx = BIN_WTH'(i);
            end
        end
    end

    // Strictly one-hot: non-zero and clearing the lowest set bit leaves nothing.
    assign enc_err = (data_i == '0) || ((data_i & (data_i - OHOT_WTH'(1))) != '0);
    assign accept  = in_vld_i & in_rdy_o;

    enc_onehot_skid_q #(
        .W(BIN_WTH + 1)
    ) u_skid_q (
        .clk        (clk_i),
        .rst        (rst_i),
        .in_tvalid  (in_vld_i),
        .in_tready  (in_rdy_o),
        .in_tdata   ({enc_err, enc_idx}),
        .out_tvalid (out_vld_o),
        .out_tready (out_rdy_i),
        .out_tdata  ({err_o, data_o})
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_cnt_i) begin
            err_cnt_q <= '0;
        end else if (accept && enc_err && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_WTH'(1);
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_enc_onehot_to_bin_pipe.sv
// tb/tb_enc_onehot_to_bin_pipe.sv - self-checking bench for enc_onehot_to_bin_pipe

module tb_enc_onehot_to_bin_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld;
    logic [7:0]  data_in;
    logic        out_rdy;
    logic        clr_cnt;

    logic        in_rdy, out_vld, err;
    logic [2:0]  data_out;
    logic [15:0] err_cnt;

    logic        s_in_rdy, s_out_vld, s_err;
    logic [2:0]  s_data_out;
    logic [1:0]  s_err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    enc_onehot_to_bin_pipe #(.OHOT_WTH(8), .BIN_WTH(3), .ERR_CNT_WTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_vld_i(in_vld), .in_rdy_o(in_rdy), .data_i(data_in),
        .out_vld_o(out_vld), .out_rdy_i(out_rdy), .data_o(data_out), .err_o(err),
        .clr_cnt_i(clr_cnt), .err_cnt_o(err_cnt)
    );

    enc_onehot_to_bin_pipe #(.OHOT_WTH(8), .BIN_WTH(3), .ERR_CNT_WTH(2)) dut_small (
        .clk_i(clk), .rst_i(rst), .in_vld_i(in_vld), .in_rdy_o(s_in_rdy), .data_i(data_in),
        .out_vld_o(s_out_vld), .out_rdy_i(out_rdy), .data_o(s_data_out), .err_o(s_err),
        .clr_cnt_i(clr_cnt), .err_cnt_o(s_err_cnt)
    );

    // Model: a FIFO of capacity 2 holding {err, index}, plus two saturating counters.
    logic [3:0] mq[$];
    int         m_cnt  = 0;
    int         m_scnt = 0;

    function automatic logic [3:0] model_enc(input logic [7:0] d);
        int idx = 0;
        for (int i = 7; i >= 0; i--) if (d[i]) idx = i;
        return {($countones(d) != 1), 3'(idx)};
    endfunction

    always @(posedge clk) begin
        bit acc, con;
        acc = in_vld && (mq.size() < 2);
        con = out_rdy && (mq.size() > 0);
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_scnt = 0;
        end else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(model_enc(data_in));
            if (clr_cnt) begin
                m_cnt  = 0;
                m_scnt = 0;
            end else if (acc && model_enc(data_in)[3]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_scnt < 3) m_scnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checks < 100000) begin
            chk("m_out_vld", 32'(out_vld), 32'(mq.size() > 0));
            chk("m_in_rdy", 32'(in_rdy), 32'(mq.size() < 2));
            chk("m_err_cnt", 32'(err_cnt), 32'(m_cnt));
            chk("m_s_err_cnt", 32'(s_err_cnt), 32'(m_scnt));
            chk("m_s_out_vld", 32'(s_out_vld), 32'(mq.size() > 0));
            chk("m_s_in_rdy", 32'(s_in_rdy), 32'(mq.size() < 2));
            if (mq.size() > 0) begin
                chk("m_data", 32'(data_out), 32'(mq[0][2:0]));
                chk("m_err", 32'(err), 32'(mq[0][3]));
                chk("m_s_data", 32'(s_data_out), 32'(mq[0][2:0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b1; data_in = 8'h04; out_rdy = 1'b1; clr_cnt = 1'b0;

        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_out_vld", 32'(out_vld), 0);
            chk("rst_cnt", 32'(err_cnt), 0);
            chk("rst_in_rdy", 32'(in_rdy), 1);
            chk("rst_data", 32'(data_out), 0);
        end
        rst = 1'b0;
        cyc();
        chk("first_vld", 32'(out_vld), 1);
        chk("first_data", 32'(data_out), 2);
        in_vld = 1'b0;
        cyc();
        chk("first_drained", 32'(out_vld), 0);

        // Sweep of legal one-hot vectors, full throughput.
        for (int i = 0; i < 8; i++) begin
            in_vld = 1'b1; data_in = 8'(1 << i);
            cyc();
            chk("sweep_data", 32'(data_out), 32'(i));
            chk("sweep_err", 32'(err), 0);
            chk("sweep_rdy", 32'(in_rdy), 1);
        end
        in_vld = 1'b0;
        cyc();
        chk("sweep_cnt", 32'(err_cnt), 0);

        // Backpressure fills both entries, then drains in order.
        out_rdy = 1'b0; in_vld = 1'b1; data_in = 8'h08;
        cyc();
        chk("bp_rdy1", 32'(in_rdy), 1);
        data_in = 8'h10;
        cyc();
        chk("bp_rdy2", 32'(in_rdy), 0);
        data_in = 8'h20;
        cyc();
        chk("bp_hold_data", 32'(data_out), 3);
        chk("bp_hold_rdy", 32'(in_rdy), 0);
        out_rdy = 1'b1;
        cyc();
        chk("bp_out4", 32'(data_out), 4);
        chk("bp_rdy_back", 32'(in_rdy), 1);
        cyc();
        chk("bp_out5", 32'(data_out), 5);
        in_vld = 1'b0;
        cyc();
        chk("bp_empty", 32'(out_vld), 0);

        // Non-one-hot vectors.
        in_vld = 1'b1; data_in = 8'h00;
        cyc();
        chk("ill00_data", 32'(data_out), 0);
        chk("ill00_err", 32'(err), 1);
        data_in = 8'h24;
        cyc();
        chk("ill24_data", 32'(data_out), 2);
        chk("ill24_err", 32'(err), 1);
        data_in = 8'hFF;
        cyc();
        chk("illff_data", 32'(data_out), 0);
        chk("illff_err", 32'(err), 1);
        in_vld = 1'b0;
        cyc();
        chk("ill_cnt", 32'(err_cnt), 3);

        // Saturation on the 2-bit counter, then clear beating an increment.
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(err_cnt), 0);
        in_vld = 1'b1; data_in = 8'h00;
        for (int i = 0; i < 5; i++) cyc();
        chk("sat_small", 32'(s_err_cnt), 3);
        chk("sat_wide", 32'(err_cnt), 5);
        clr_cnt = 1'b1;
        cyc();
        chk("clr_win_small", 32'(s_err_cnt), 0);
        chk("clr_win_wide", 32'(err_cnt), 0);
        clr_cnt = 1'b0; in_vld = 1'b0;
        cyc();
        cyc();

        // Reset with both entries occupied.
        out_rdy = 1'b0; in_vld = 1'b1; data_in = 8'h01;
        cyc();
        data_in = 8'h02;
        cyc();
        in_vld = 1'b0;
        chk("mid_full", 32'(in_rdy), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_vld", 32'(out_vld), 0);
        chk("mid_rdy", 32'(in_rdy), 1);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("mid_no_ghost", 32'(out_vld), 0);
        end
        in_vld = 1'b1; data_in = 8'h80;
        cyc();
        chk("post_rst_data", 32'(data_out), 7);
        in_vld = 1'b0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
